tnn_feature_packer: RTL and testbench

Upstream input stage for the evolved approximate TNN neuron circuits. Accepts a stream of raw unsigned features, one per handshake, and quantizes each to 2 bits against three thresholds. It assembles `N_FEAT` quantized features into one packed frame and presents that frame with valid/ready to the neuron. Feature i of a frame lands in `out_frame[2i+1:2i]`, so features 0..4 drive the neuron's `input_a`..`input_e`.

---
 rtl/tnn_feature_packer.sv | 145 ++++++++++++++
 tb/tb_tnn_feature_packer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tnn_feature_packer.sv
// Quantizes raw features to 2-bit codes and packs N_FEAT of them per frame; optional TNN_THRESH_PROG_EN adds threshold write port.
// Latency: closing feature accepted at edge k -> out_valid with that frame after edge k.
// Backpressure: only the closing feature stalls, and only against a held, undrained output frame.
module tnn_feature_packer #(
    parameter int N_FEAT = 5,
    parameter int IN_W   = 8,
    parameter int TH0    = 64,
    parameter int TH1    = 128,
    parameter int TH2    = 192
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*N_FEAT-1:0]   out_frame,
    output logic                  out_err
`ifdef TNN_THRESH_PROG_EN
    ,
    input  logic                  th_we,
    input  logic [1:0]            th_sel,
    input  logic [IN_W-1:0]       th_wdata
`endif
);

    localparam int CNT_W = $clog2(N_FEAT);
    localparam int FW    = 2 * N_FEAT;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_FEAT - 1);

    logic [IN_W-1:0] th0, th1, th2;

`ifdef TNN_THRESH_PROG_EN
    logic [IN_W-1:0] th0_q, th1_q, th2_q;
    logic [IN_W-1:0] th0_d, th1_d, th2_d;

    always_comb begin
        th0_d = th0_q;
        th1_d = th1_q;
        th2_d = th2_q;
        if (th_we) begin
            case (th_sel)
                2'd0:    th0_d = th_wdata;
                2'd1:    th1_d = th_wdata;
                2'd2:    th2_d = th_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th0_q <= IN_W'(TH0);
            th1_q <= IN_W'(TH1);
            th2_q <= IN_W'(TH2);
        end else begin
            th0_q <= th0_d;
            th1_q <= th1_d;
            th2_q <= th2_d;
        end
    end

    assign th0 = th0_q;
    assign th1 = th1_q;
    assign th2 = th2_q;
`else
    assign th0 = IN_W'(TH0);
    assign th1 = IN_W'(TH1);
    assign th2 = IN_W'(TH2);
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FW-1:0]    asm_q, asm_d;
    logic             out_valid_q, out_valid_d;
    logic [FW-1:0]    out_frame_q, out_frame_d;
    logic             out_err_q, out_err_d;

    logic [1:0]       code;
    logic [FW-1:0]    frame_fill;
    logic             is_full, closing, accept;

    always_comb begin
        if (in_data >= th2)      code = 2'd3;
        else if (in_data >= th1) code = 2'd2;
        else if (in_data >= th0) code = 2'd1;
        else                     code = 2'd0;
    end

    assign is_full  = (cnt_q == LAST_IDX);
    assign closing  = is_full | in_last;
    assign in_ready = rst_n & ~(closing & out_valid_q & ~out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_valid_d = out_valid_q;
        out_frame_d = out_frame_q;
        out_err_d   = out_err_q;

        // Slots above cnt are always zero, so this also zero-fills an early close.
        frame_fill = asm_q;
        for (int i = 0; i < N_FEAT; i++) begin
            if (cnt_q == CNT_W'(i)) frame_fill[2*i +: 2] = code;
        end

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        if (accept) begin
            if (closing) begin
                cnt_d       = '0;
                asm_d       = '0;
                out_valid_d = 1'b1;
                out_frame_d = frame_fill;
                out_err_d   = in_last ^ is_full;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                asm_d = frame_fill;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            out_frame_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            out_frame_q <= out_frame_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_frame = out_frame_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_tnn_feature_packer.sv
// Directed bench for tnn_feature_packer with hand-computed frames and an in-order frame scoreboard.
module tb_tnn_feature_packer;

    localparam int N_FEAT = 5;
    localparam int IN_W   = 8;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [IN_W-1:0]     in_data = '0;
    logic                in_last = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [2*N_FEAT-1:0] out_frame;
    logic                out_err;
`ifdef TNN_THRESH_PROG_EN
    logic                th_we = 1'b0;
    logic [1:0]          th_sel = 2'd0;
    logic [IN_W-1:0]     th_wdata = '0;
`endif

    tnn_feature_packer #(
        .N_FEAT(N_FEAT), .IN_W(IN_W), .TH0(64), .TH1(128), .TH2(192)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_frame (out_frame),
        .out_err   (out_err)
`ifdef TNN_THRESH_PROG_EN
        ,
        .th_we     (th_we),
        .th_sel    (th_sel),
        .th_wdata  (th_wdata)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [10:0] exp_q[$];
    logic [10:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every drained frame is logged as {err, frame}.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) got_q.push_back({out_err, out_frame});
    end

    task automatic send(input logic [IN_W-1:0] d, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        out_ready = 1'b1;
        #13;
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_frame", out_frame, 0);
        chk("rst_out_err",   out_err,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Codes 0,1,1,3,3
        send(8'd0, 0); send(8'd64, 0); send(8'd127, 0); send(8'd192, 0);
        chk("basic_no_early_valid", out_valid, 0);
        send(8'd255, 1);
        chk("basic_valid", out_valid, 1);
        chk("basic_frame", out_frame, 10'h3D4);
        chk("basic_err",   out_err,   0);
        exp_q.push_back({1'b0, 10'h3D4});
        @(posedge clk); #1;
        chk("basic_one_cycle", out_valid, 0);

        // Backpressure: frame A held, frame B closing feature must stall
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'd128, (i == 4));
        exp_q.push_back({1'b0, 10'h2AA});
        chk("bp_a_valid", out_valid, 1);
        send(8'd0, 0); send(8'd255, 0); send(8'd0, 0); send(8'd255, 0);
        in_valid = 1'b1; in_data = 8'd64; in_last = 1'b1;
        #1;
        chk("bp_stall0", in_ready, 0);
        @(posedge clk); #1;
        chk("bp_stall1", in_ready, 0);
        chk("bp_hold_frame", out_frame, 10'h2AA);
        out_ready = 1'b1;
        #1;
        chk("bp_release", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_frame", out_frame, 10'h1CC);
        exp_q.push_back({1'b0, 10'h1CC});
        @(posedge clk); #1;
        chk("bp_drained", out_valid, 0);

        // Early close
        send(8'd255, 0); send(8'd255, 0); send(8'd255, 1);
        chk("early_frame", out_frame, 10'h03F);
        chk("early_err",   out_err,   1);
        exp_q.push_back({1'b1, 10'h03F});
        send(8'd255, 0); send(8'd0, 0); send(8'd0, 0); send(8'd0, 0); send(8'd0, 1);
        chk("after_early_frame", out_frame, 10'h003);
        chk("after_early_err",   out_err,   0);
        exp_q.push_back({1'b0, 10'h003});

        // Missing last
        for (int i = 0; i < 5; i++) send(8'd128, 0);
        chk("nolast_valid", out_valid, 1);
        chk("nolast_frame", out_frame, 10'h2AA);
        chk("nolast_err",   out_err,   1);
        exp_q.push_back({1'b1, 10'h2AA});
        send(8'd192, 1);
        chk("sixth_frame", out_frame, 10'h003);
        chk("sixth_err",   out_err,   1);
        exp_q.push_back({1'b1, 10'h003});

        // Reset with a partial frame
        send(8'd255, 0); send(8'd255, 0); send(8'd255, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready",  in_ready,  0);
        chk("midrst_out_frame", out_frame, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) send(8'd64, (i == 4));
        chk("clean_frame", out_frame, 10'h155);
        chk("clean_err",   out_err,   0);
        exp_q.push_back({1'b0, 10'h155});

`ifdef TNN_THRESH_PROG_EN
        th_we = 1'b1; th_sel = 2'd0; th_wdata = 8'd10;
        @(posedge clk); #1;
        th_we = 1'b0;
        send(8'd10, 1);
        chk("prog_th0_10", out_frame, 10'h001);
        exp_q.push_back({1'b1, 10'h001});
        th_we = 1'b1; th_sel = 2'd0; th_wdata = 8'd200;
        send(8'd100, 1);
        th_we = 1'b0;
        chk("prog_same_edge_old", out_frame, 10'h001);
        exp_q.push_back({1'b1, 10'h001});
        send(8'd100, 1);
        chk("prog_new_value", out_frame, 10'h000);
        exp_q.push_back({1'b1, 10'h000});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("frame_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("frame_%0d", i), got_q[i], exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
